// File: rtl/systolic_weight_loader_pkg.sv
// Shared definitions for the systolic weight loader: loader FSM states,
// default weight width and the index-width helper.
package systolic_weight_loader_pkg;

    // Weight width shared with the PE array and its testbench.
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_FULL  = 2'd1,
        S_SHIFT = 2'd2,
        S_SWAP  = 2'd3
    } state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_tile_buf.sv
// Tile buffer: ROWS entries of one row-vector each, one write port and one
// registered read port whose register clears when no read is requested.
// Ports: clk, rst_n, wr_en/wr_idx/wr_data (write), rd_en/rd_idx (read
// request), rd_data (registered read data, 0 when rd_en was low).
module weight_tile_buf
    import systolic_weight_loader_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int LW   = 128,
    parameter int IW   = idx_w(ROWS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [LW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_idx,
    output logic [LW-1:0] rd_data
);

    logic [LW-1:0] r_mem [ROWS];
    logic [LW-1:0] r_rd;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    // The read register is what the array sees, so it idles at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= '0;
        end else begin
            r_rd <= rd_en ? r_mem[rd_idx] : '0;
        end
    end

    assign rd_data = r_rd;

endmodule

// File: rtl/systolic_weight_loader.sv
// Loads a ROWS x COLS weight tile into a systolic array: buffers row-vectors
// (valid/ready), shifts them down last row first, then pulses switch.
// Ports: clk, rst_n, in_valid/in_ready/in_row (row input), hold (stall start
// of shift), b_out (row-0 b inputs), switch_out (swap pulse), busy.
module systolic_weight_loader
    import systolic_weight_loader_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [COLS*DW-1:0] in_row,
    input  logic             hold,
    output logic [COLS*DW-1:0] b_out,
    output logic             switch_out,
    output logic             busy
);

    localparam int IW = idx_w(ROWS);
    localparam int LW = COLS * DW;
    localparam logic [IW-1:0] LAST = IW'(ROWS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_cnt;
    logic [IW-1:0] r_sidx;
    logic [IW-1:0] w_rd_idx;
    logic          w_acc;
    logic          w_rd_en;
    logic          r_switch;

    assign in_ready = (r_state == S_FILL);
    assign w_acc    = in_valid && in_ready;
    assign busy     = (r_state == S_SHIFT) || (r_state == S_SWAP);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FILL:  if (w_acc && (r_cnt == LAST)) w_next = S_FULL;
            S_FULL:  if (!hold) w_next = S_SHIFT;
            S_SHIFT: if (r_sidx == LAST) w_next = S_SWAP;
            S_SWAP:  w_next = S_FILL;
            default: w_next = S_FILL;
        endcase
    end

    // The read register is loaded one cycle ahead of the pins: leaving FULL
    // fetches the last row, each SHIFT cycle fetches the row above.
    always_comb begin
        w_rd_en  = (w_next == S_SHIFT);
        w_rd_idx = LAST;
        if ((r_state == S_SHIFT) && (r_sidx != LAST)) begin
            w_rd_idx = LAST - r_sidx - IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FILL;
            r_cnt    <= '0;
            r_sidx   <= '0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_switch <= (w_next == S_SWAP);
            if (w_acc) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + IW'(1);
            end
            if (r_state == S_SHIFT) begin
                r_sidx <= (r_sidx == LAST) ? '0 : r_sidx + IW'(1);
            end else begin
                r_sidx <= '0;
            end
        end
    end

    assign switch_out = r_switch;

    weight_tile_buf #(
        .ROWS (ROWS),
        .LW   (LW),
        .IW   (IW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_acc),
        .wr_idx  (r_cnt),
        .wr_data (in_row),
        .rd_en   (w_rd_en),
        .rd_idx  (w_rd_idx),
        .rd_data (b_out)
    );

endmodule

// File: tb/tb_systolic_weight_loader.sv
// Bench for systolic_weight_loader driving a behavioural 4x4 PE array
// (dormant shift chain + active copy on switch).
module tb_systolic_weight_loader;
    import systolic_weight_loader_pkg::*;

    localparam int DW   = DEF_DW;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int LW   = COLS * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_row;
    logic          hold;
    logic [LW-1:0] b_out;
    logic          switch_out;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_sw  = 0;

    logic [DW-1:0] dorm [ROWS][COLS];
    logic [DW-1:0] act  [ROWS][COLS];
    logic [LW-1:0] tile [ROWS];
    logic [LW-1:0] snap [ROWS];

    always #5 clk = ~clk;

    systolic_weight_loader #(
        .DW   (DW),
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .hold       (hold),
        .b_out      (b_out),
        .switch_out (switch_out),
        .busy       (busy)
    );

    // PE array model: dormant regs load b every edge, active copies on switch.
    always @(posedge clk) begin
        for (int r = ROWS - 1; r > 0; r--)
            for (int j = 0; j < COLS; j++)
                dorm[r][j] <= dorm[r-1][j];
        for (int j = 0; j < COLS; j++)
            dorm[0][j] <= b_out[j*DW +: DW];
        if (switch_out)
            for (int r = 0; r < ROWS; r++)
                for (int j = 0; j < COLS; j++)
                    act[r][j] <= dorm[r][j];
    end

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) n_acc++;
        if (switch_out) n_sw++;
    end

    function automatic logic [LW-1:0] mkrow(input int base, input int step);
        logic [LW-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*DW +: DW] = DW'(base + j * step);
        return v;
    endfunction

    function automatic logic [LW-1:0] act_row(input int r);
        logic [LW-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*DW +: DW] = act[r][j];
        return v;
    endfunction

    function automatic logic [DW-1:0] colsum(input int j);
        logic [DW-1:0] s = '0;
        for (int r = 0; r < ROWS; r++) s = s + act[r][j];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [LW-1:0] d);
        bit done = 1'b0;
        in_row   = d;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("push_accepted", done, 1);
    endtask

    // Entered at a FULL negedge with hold low; checks SHIFT, SWAP, result.
    task automatic drain(input string tag, input int hold_at);
        logic [LW-1:0] pre [ROWS];
        for (int r = 0; r < ROWS; r++) pre[r] = act_row(r);
        for (int k = 0; k < ROWS; k++) begin
            @(negedge clk);
            chk({tag, "_shift_b"}, b_out, tile[ROWS-1-k]);
            chk({tag, "_shift_busy"}, busy, 1);
            chk({tag, "_shift_sw"}, switch_out, 0);
            if (k == hold_at) hold = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_swap_sw"}, switch_out, 1);
        chk({tag, "_swap_b"}, b_out, 0);
        chk({tag, "_swap_busy"}, busy, 1);
        for (int r = 0; r < ROWS; r++)
            chk({tag, "_swap_act_old"}, act_row(r), pre[r]);
        @(negedge clk);
        chk({tag, "_post_sw"}, switch_out, 0);
        chk({tag, "_post_ready"}, in_ready, 1);
        chk({tag, "_post_busy"}, busy, 0);
        for (int r = 0; r < ROWS; r++)
            chk({tag, "_act"}, act_row(r), tile[r]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        int idx;
        int sw0;
        bit v;
        bit acc;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        in_row   = '0;
        repeat (2) @(negedge clk);
        chk("rst_b", b_out, 0);
        chk("rst_sw", switch_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", in_ready, 1);
        chk("rel_b", b_out, 0);

        // 1: basic tile, hold low
        for (int r = 0; r < ROWS; r++) tile[r] = mkrow(16 * r, 1);
        for (int r = 0; r < ROWS; r++) push(tile[r]);
        chk("t1_full_ready", in_ready, 0);
        chk("t1_full_busy", busy, 0);
        drain("t1", -1);

        // 2: hold for 10 cycles with a pending source
        hold = 1'b1;
        for (int r = 0; r < ROWS; r++) tile[r] = mkrow(256 + 16 * r, 3);
        for (int r = 0; r < ROWS; r++) push(tile[r]);
        a0       = n_acc;
        in_valid = 1'b1;
        in_row   = mkrow(999, 0);
        repeat (10) begin
            chk("t2_hold_ready", in_ready, 0);
            chk("t2_hold_b", b_out, 0);
            chk("t2_hold_sw", switch_out, 0);
            chk("t2_hold_busy", busy, 0);
            @(negedge clk);
        end
        chk("t2_no_accept", n_acc - a0, 0);
        in_valid = 1'b0;
        hold     = 1'b0;
        drain("t2", -1);

        // 3: random valid gaps
        hold = 1'b1;
        for (int r = 0; r < ROWS; r++) tile[r] = mkrow(4096 + 16 * r, 5);
        a0  = n_acc;
        idx = 0;
        for (int c = 0; c < 200 && idx < ROWS; c++) begin
            v        = 1'($urandom_range(0, 1));
            in_valid = v;
            in_row   = tile[idx];
            acc      = v && in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        chk("t3_rows", idx, ROWS);
        in_valid = 1'b1;
        in_row   = mkrow(77, 0);
        repeat (5) @(negedge clk);
        chk("t3_accepts", n_acc - a0, ROWS);
        in_valid = 1'b0;
        hold     = 1'b0;
        drain("t3", -1);

        // 4: back-to-back tiles A then B
        for (int r = 0; r < ROWS; r++) tile[r] = mkrow(1, 0);
        for (int r = 0; r < ROWS; r++) push(tile[r]);
        drain("t4a", -1);
        for (int j = 0; j < COLS; j++) chk("t4_sum_a", colsum(j), 4);
        for (int r = 0; r < ROWS; r++) tile[r] = mkrow(2, 0);
        for (int r = 0; r < ROWS; r++) push(tile[r]);
        for (int j = 0; j < COLS; j++) chk("t4_sum_pre", colsum(j), 4);
        drain("t4b", -1);
        for (int j = 0; j < COLS; j++) chk("t4_sum_b", colsum(j), 8);

        // 5: reset in SHIFT cycle 2
        for (int r = 0; r < ROWS; r++) tile[r] = mkrow(1280 + 16 * r, 1);
        for (int r = 0; r < ROWS; r++) push(tile[r]);
        for (int r = 0; r < ROWS; r++) snap[r] = act_row(r);
        sw0 = n_sw;
        repeat (3) @(negedge clk);
        chk("t5_in_shift2", b_out, tile[1]);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_b", b_out, 0);
        chk("t5_rst_sw", switch_out, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_rel_b", b_out, 0);
        chk("t5_rel_sw", switch_out, 0);
        chk("t5_rel_busy", busy, 0);
        chk("t5_rel_ready", in_ready, 1);
        chk("t5_no_pulse", n_sw - sw0, 0);
        for (int r = 0; r < ROWS; r++) chk("t5_act_kept", act_row(r), snap[r]);

        // 6: hold raised in SHIFT cycle 1
        for (int r = 0; r < ROWS; r++) tile[r] = mkrow(1792 + 16 * r, 7);
        for (int r = 0; r < ROWS; r++) push(tile[r]);
        drain("t6", 1);
        hold = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
